// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : seq_det_pkg
//  Purpose   : Shared state encoding and width helper for seq_detector_param.
//              Pattern bit order: pat[len-1] is the first bit received on
//              the serial line and pat[0] is the most recent one.
//  Revision  : 1.0  initial release
// ============================================================================
package seq_det_pkg;

    // Detector control states, 2-bit encoding
    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Width needed to hold a pattern length in the range 0..pat_w
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module    : sat_counter
//  Purpose   : Up-counter that sticks at all-ones; synchronous clear has
//              priority over increment.
//  Revision  : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Clear wins; otherwise count up unless already saturated
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module    : seq_detector_param
//  Purpose   : Runtime-programmable serial pattern detector. Pattern, length
//              and overlap mode are loaded via cfg_load; a Mealy match pulse
//              fires on the completing qualified bit and a saturating counter
//              tallies matches.
//  Revision  : 1.0  initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16,
    localparam int LEN_W = len_width(PAT_W)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pat,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed,
    output logic             cfg_err
);

    state_t           state;
    logic [PAT_W-1:0] cfg_pat;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_ovl;
    logic [PAT_W-2:0] history;
    logic [PAT_W-2:0] history_shifted;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_inc;
    logic [PAT_W-1:0] window;
    logic [PAT_W-1:0] len_mask;
    logic             hit;
    logic             len_legal;

    // History after accepting the current bit (in_bit enters the LSB)
    generate
        if (PAT_W > 2) begin : g_hist_wide
            assign history_shifted = {history[PAT_W-3:0], in_bit};
        end else begin : g_hist_single
            assign history_shifted = in_bit;
        end
    endgenerate

    assign fill_inc  = fill + LEN_W'(1);
    assign len_legal = (pat_len != '0) && (int'(pat_len) <= PAT_W);

    // Candidate window: stored history followed by the bit on the wire now
    assign window = {history, in_bit};

    // Only the low cfg_len bits take part in the comparison
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(cfg_len));
        end
    end

    assign hit   = ((window ^ cfg_pat) & len_mask) == '0;

    // A bit arriving together with cfg_load belongs to the old search and is dropped
    assign match = in_valid & ~cfg_load & (state == ST_ARMED) & hit;

    // Control FSM: config capture, history/fill tracking, registered armed/cfg_err
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_UNCFG;
            cfg_pat <= '0;
            cfg_len <= '0;
            cfg_ovl <= 1'b0;
            history <= '0;
            fill    <= '0;
            armed   <= 1'b0;
            cfg_err <= 1'b0;
        end else if (cfg_load) begin
            cfg_pat <= pat;
            cfg_len <= pat_len;
            cfg_ovl <= overlap_en;
            history <= '0;
            fill    <= '0;
            if (!len_legal) begin
                state   <= ST_ERR;
                armed   <= 1'b0;
                cfg_err <= 1'b1;
            end else if (pat_len == LEN_W'(1)) begin
                // A one-bit pattern needs no history
                state   <= ST_ARMED;
                armed   <= 1'b1;
                cfg_err <= 1'b0;
            end else begin
                state   <= ST_FILL;
                armed   <= 1'b0;
                cfg_err <= 1'b0;
            end
        end else if (in_valid) begin
            case (state)
                ST_FILL: begin
                    history <= history_shifted;
                    fill    <= fill_inc;
                    if (fill_inc == (cfg_len - LEN_W'(1))) begin
                        state <= ST_ARMED;
                        armed <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (hit && !cfg_ovl) begin
                        // Non-overlapping: the matched bits cannot start the next match
                        history <= '0;
                        fill    <= '0;
                        if (cfg_len != LEN_W'(1)) begin
                            state <= ST_FILL;
                            armed <= 1'b0;
                        end
                    end else begin
                        history <= history_shifted;
                    end
                end
                default: begin
                    // UNCFG and ERR ignore incoming bits
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (match),
        .clr     (clear_count),
        .count   (match_count)
    );

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module    : tb_seq_detector_param
//  Purpose   : Self-checking bench for seq_detector_param: directed vector
//              table, hand-written corner sequences and a randomized run
//              against a queue-based reference model.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_seq_detector_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] pat = '0;
    logic [LEN_W-1:0] pat_len = '0;
    logic             overlap_en = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             clear_count = 1'b0;

    logic             match, match2;
    logic [15:0]      match_count;
    logic [1:0]       match_count2;
    logic             armed, armed2;
    logic             cfg_err, cfg_err2;

    int errors = 0;
    int checks = 0;
    logic s_match;

    always #5 clk = ~clk;

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(16)) dut (
        .clock(clk), .reset_n(reset_n), .cfg_load(cfg_load), .pat(pat),
        .pat_len(pat_len), .overlap_en(overlap_en), .in_valid(in_valid),
        .in_bit(in_bit), .clear_count(clear_count), .match(match),
        .match_count(match_count), .armed(armed), .cfg_err(cfg_err)
    );

    seq_detector_param #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clock(clk), .reset_n(reset_n), .cfg_load(cfg_load), .pat(pat),
        .pat_len(pat_len), .overlap_en(overlap_en), .in_valid(in_valid),
        .in_bit(in_bit), .clear_count(clear_count), .match(match2),
        .match_count(match_count2), .armed(armed2), .cfg_err(cfg_err2)
    );

    // ---------------- reference model ----------------
    bit         m_cfg_ok;
    bit         m_err;
    int         m_len;
    int         m_pat;
    bit         m_ovl;
    bit         hist[$];
    int         m_cnt;
    int         m_cnt2;

    task automatic model_reset();
        m_cfg_ok = 0; m_err = 0; m_len = 0; m_pat = 0; m_ovl = 0;
        hist.delete(); m_cnt = 0; m_cnt2 = 0;
    endtask

    // Last len-1 accepted bits followed by the current bit must equal the pattern
    function automatic logic model_match();
        int w;
        if (!m_cfg_ok || cfg_load || !in_valid) return 1'b0;
        if (hist.size() < m_len - 1) return 1'b0;
        w = 0;
        for (int i = m_len - 2; i >= 0; i--) w = (w << 1) | int'(hist[hist.size() - 1 - i]);
        w = (w << 1) | int'(in_bit);
        return (w == (m_pat & ((1 << m_len) - 1)));
    endfunction

    task automatic model_clock(input logic em);
        if (cfg_load) begin
            m_len    = int'(pat_len);
            m_pat    = int'(pat);
            m_ovl    = overlap_en;
            m_cfg_ok = (m_len >= 1) && (m_len <= PAT_W);
            m_err    = !m_cfg_ok;
            hist.delete();
        end else if (m_cfg_ok && in_valid) begin
            if (em && !m_ovl) hist.delete();
            else begin
                hist.push_back(in_bit);
                while (hist.size() > PAT_W - 1) void'(hist.pop_front());
            end
        end
        if (clear_count) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (em) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    function automatic logic model_armed();
        return m_cfg_ok && (hist.size() >= m_len - 1);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive, check Mealy output before the edge, registered outputs after it
    task automatic step(input logic cl, input logic [7:0] p, input logic [3:0] l,
                        input logic ov, input logic v, input logic b, input logic cc);
        logic em;
        @(negedge clk);
        cfg_load = cl; pat = p; pat_len = l; overlap_en = ov;
        in_valid = v; in_bit = b; clear_count = cc;
        #1;
        em = model_match();
        s_match = match;
        chk("match", match, em);
        chk("match2", match2, em);
        @(posedge clk);
        model_clock(em);
        #1;
        chk("armed", armed, model_armed());
        chk("cfg_err", cfg_err, m_err);
        chk("count", match_count, m_cnt);
        chk("count2", match_count2, m_cnt2);
    endtask

    typedef struct {
        logic       cl;
        logic [7:0] p;
        logic [3:0] l;
        logic       ov;
        logic       v;
        logic       b;
        logic       cc;
        logic       e_match;
        int         e_cnt;
        logic       e_armed;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic cl, input logic [7:0] p, input logic [3:0] l, input logic ov,
                       input logic v, input logic b, input logic cc,
                       input logic em, input int ec, input logic ea, input logic ee);
        vec_t t;
        t.cl = cl; t.p = p; t.l = l; t.ov = ov; t.v = v; t.b = b; t.cc = cc;
        t.e_match = em; t.e_cnt = ec; t.e_armed = ea; t.e_err = ee;
        tbl.push_back(t);
    endtask

    initial begin
        int exp2[6];
        model_reset();
        // reset state
        #3;
        chk("rst_match", match, 1'b0);
        chk("rst_armed", armed, 1'b0);
        chk("rst_err", cfg_err, 1'b0);
        chk("rst_count", match_count, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;

        //   cl  pat         len ov v  b  cc   match cnt armed err
        // overlapping 1001
        add(1, 8'b00001001, 4, 1, 0, 0, 0,  0, 0, 0, 0);
        add(0, 8'b00001001, 4, 1, 1, 1, 0,  0, 0, 0, 0);
        add(0, 8'b00001001, 4, 1, 1, 0, 0,  0, 0, 0, 0);
        add(0, 8'b00001001, 4, 1, 1, 0, 0,  0, 0, 1, 0);
        add(0, 8'b00001001, 4, 1, 1, 1, 0,  1, 1, 1, 0);
        add(0, 8'b00001001, 4, 1, 1, 0, 0,  0, 1, 1, 0);
        add(0, 8'b00001001, 4, 1, 1, 0, 0,  0, 1, 1, 0);
        add(0, 8'b00001001, 4, 1, 1, 1, 0,  1, 2, 1, 0);
        // non-overlapping, counter cleared together with the reload
        add(1, 8'b00001001, 4, 0, 0, 0, 1,  0, 0, 0, 0);
        add(0, 8'b00001001, 4, 0, 1, 1, 0,  0, 0, 0, 0);
        add(0, 8'b00001001, 4, 0, 1, 0, 0,  0, 0, 0, 0);
        add(0, 8'b00001001, 4, 0, 1, 0, 0,  0, 0, 1, 0);
        add(0, 8'b00001001, 4, 0, 1, 1, 0,  1, 1, 0, 0);
        add(0, 8'b00001001, 4, 0, 1, 0, 0,  0, 1, 0, 0);
        add(0, 8'b00001001, 4, 0, 1, 0, 0,  0, 1, 0, 0);
        add(0, 8'b00001001, 4, 0, 1, 1, 0,  0, 1, 1, 0);
        // bubbles between bits 1,0,0,1
        add(1, 8'b00001001, 4, 1, 0, 0, 0,  0, 1, 0, 0);
        add(0, 8'b00001001, 4, 1, 1, 1, 0,  0, 1, 0, 0);
        add(0, 8'b00001001, 4, 1, 0, 0, 0,  0, 1, 0, 0);
        add(0, 8'b00001001, 4, 1, 1, 0, 0,  0, 1, 0, 0);
        add(0, 8'b00001001, 4, 1, 0, 1, 0,  0, 1, 0, 0);
        add(0, 8'b00001001, 4, 1, 0, 1, 0,  0, 1, 0, 0);
        add(0, 8'b00001001, 4, 1, 1, 0, 0,  0, 1, 1, 0);
        add(0, 8'b00001001, 4, 1, 0, 1, 0,  0, 1, 1, 0);
        add(0, 8'b00001001, 4, 1, 0, 1, 0,  0, 1, 1, 0);
        add(0, 8'b00001001, 4, 1, 0, 1, 0,  0, 1, 1, 0);
        add(0, 8'b00001001, 4, 1, 1, 1, 0,  1, 2, 1, 0);
        // illegal length 0, then len=1 pat=1
        add(1, 8'b00000001, 0, 1, 0, 0, 0,  0, 2, 0, 1);
        add(0, 8'b00000001, 0, 1, 1, 1, 0,  0, 2, 0, 1);
        add(0, 8'b00000001, 0, 1, 1, 1, 0,  0, 2, 0, 1);
        add(0, 8'b00000001, 0, 1, 1, 1, 0,  0, 2, 0, 1);
        add(0, 8'b00000001, 0, 1, 1, 1, 0,  0, 2, 0, 1);
        add(1, 8'b00000001, 1, 1, 0, 0, 0,  0, 2, 1, 0);
        add(0, 8'b00000001, 1, 1, 1, 1, 0,  1, 3, 1, 0);
        add(0, 8'b00000001, 1, 1, 1, 0, 0,  0, 3, 1, 0);
        add(0, 8'b00000001, 1, 1, 1, 1, 0,  1, 4, 1, 0);
        // cfg_load beats a simultaneous bit; clear beats a simultaneous match
        add(1, 8'b00000001, 1, 1, 1, 1, 0,  0, 4, 1, 0);
        add(0, 8'b00000001, 1, 1, 1, 1, 1,  1, 0, 1, 0);
        // length above PAT_W is illegal
        add(1, 8'b11111111, 9, 1, 0, 0, 0,  0, 0, 0, 1);
        add(0, 8'b11111111, 9, 1, 1, 1, 0,  0, 0, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].cl, tbl[i].p, tbl[i].l, tbl[i].ov, tbl[i].v, tbl[i].b, tbl[i].cc);
            chk($sformatf("tbl%0d_match", i), s_match, tbl[i].e_match);
            chk($sformatf("tbl%0d_count", i), match_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_armed", i), armed, tbl[i].e_armed);
            chk($sformatf("tbl%0d_err", i), cfg_err, tbl[i].e_err);
        end

        // 2-bit counter saturation, then clear together with a match
        exp2 = '{1, 2, 3, 3, 3, 3};
        step(1, 8'b1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(0, 8'b1, 1, 1, 1, 1, 0);
            chk($sformatf("sat%0d", i), match_count2, exp2[i]);
        end
        step(0, 8'b1, 1, 1, 1, 1, 1);
        chk("sat_clr_match", s_match, 1'b1);
        chk("sat_clr", match_count2, 0);
        step(0, 8'b1, 1, 1, 1, 1, 0);

        // asynchronous reset in the middle of 1,0,0,1
        step(1, 8'b00001001, 4, 1, 0, 0, 0);
        step(0, 8'b00001001, 4, 1, 1, 1, 0);
        step(0, 8'b00001001, 4, 1, 1, 0, 0);
        step(0, 8'b00001001, 4, 1, 1, 0, 0);
        chk("pre_rst_armed", armed, 1'b1);
        @(negedge clk);
        cfg_load = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_match", match, 1'b0);
        chk("arst_armed", armed, 1'b0);
        chk("arst_count", match_count, 0);
        chk("arst_count2", match_count2, 0);
        chk("arst_err", cfg_err, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        step(0, 8'b00001001, 4, 1, 1, 1, 0);
        chk("post_rst_nomatch", s_match, 1'b0);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            logic       rcl;
            logic [3:0] rl;
            rcl = ($urandom_range(0, 39) == 0) || (n == 0);
            rl  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) rl = 4'($urandom_range(6, 8));
            step(rcl, 8'($urandom), rl, 1'($urandom), ($urandom_range(0, 3) != 0),
                 1'($urandom), ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_detector_param
`default_nettype wire
